// File: rtl/zap_bpred_pkg.sv
// Shared definitions for the ZAP predecode branch predictor: FSM encoding,
// counter constants and the instruction encodings the predictor recognises.
package zap_bpred_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bpred_state_t;

    localparam logic [3:0]  COND_AL   = 4'hE;
    localparam logic [31:0] MOV_PC_LR = 32'hE1A0F00E;

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic int unsigned bpred_wnt(input int unsigned ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    function automatic int unsigned bpred_ctr_max(input int unsigned ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

endpackage

// File: rtl/zap_bpred_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module zap_bpred_ras
    import zap_bpred_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_push,
    input  logic [31:0] i_push_data,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic [31:0] o_top,
    output logic        o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] nxt_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;

    // ptr is the next write slot; the top of stack sits one slot behind it.
    always_comb begin
        nxt_ptr = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        top_ptr = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
        o_top   = mem[top_ptr];
        o_empty = (count == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (i_push) begin
            ptr   <= nxt_ptr;
            count <= (count == CNT_W'(DEPTH)) ? count : count + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            ptr   <= top_ptr;
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_flush && i_push)
            mem[ptr] <= i_push_data;
    end

endmodule

// File: rtl/zap_predecode_bpred.sv
// ZAP predecode branch predictor: bimodal BHT lookup/update, decode-time
// redirect for predicted B/BL and MOV PC, LR returns, and the RAS.
module zap_predecode_bpred
    import zap_bpred_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 1024,
    parameter int unsigned CTR_W       = 2,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear_from_writeback,
    input  logic             i_data_stall,
    input  logic             i_clear_from_alu,
    input  logic             i_stall_from_shifter,
    input  logic             i_stall_from_issue,
    input  logic             i_fetch_valid,
    input  logic [31:0]      i_fetch_pc,
    output logic [CTR_W-1:0] o_fetch_ctr,
    input  logic             i_dec_valid,
    input  logic [34:0]      i_dec_instruction,
    input  logic [31:0]      i_dec_pc_plus_8,
    input  logic [CTR_W-1:0] i_dec_ctr,
    output logic             o_clear_from_decode,
    output logic [31:0]      o_pc_from_decode,
    output logic [CTR_W-1:0] o_taken_ff,
    input  logic             i_upd_valid,
    input  logic [31:0]      i_upd_pc,
    input  logic             i_upd_taken,
    output logic             o_busy
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CTR_W-1:0] WNT     = CTR_W'(bpred_wnt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(bpred_ctr_max(CTR_W));

    bpred_state_t     state, next_state;
    logic [IDX_W-1:0] init_ptr;
    logic [CTR_W-1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [CTR_W-1:0] upd_cur, upd_ctr, lookup_ctr;
    logic             hold, active;
    logic             is_branch, is_ret, cond_al, br_redirect, ret_redirect;
    logic [31:0]      br_target, push_addr, ras_top;
    logic             ras_empty, ras_push;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_INIT;
            init_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == S_INIT)
                init_ptr <= init_ptr + IDX_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        if (state == S_INIT && init_ptr == IDX_W'(BHT_ENTRIES - 1))
            next_state = S_RUN;
    end

    assign o_busy = (state == S_INIT);

    always_comb begin
        fetch_idx = i_fetch_pc[IDX_W:1];
        upd_idx   = i_upd_pc[IDX_W:1];
        upd_cur   = bht[upd_idx];
        if (i_upd_taken)
            upd_ctr = (upd_cur == CTR_MAX) ? upd_cur : upd_cur + CTR_W'(1);
        else
            upd_ctr = (upd_cur == '0) ? upd_cur : upd_cur - CTR_W'(1);
        if (state == S_INIT)
            lookup_ctr = WNT;
        else if (i_upd_valid && upd_idx == fetch_idx)
            lookup_ctr = upd_ctr;
        else
            lookup_ctr = bht[fetch_idx];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == S_INIT)
                bht[init_ptr] <= WNT;
            else if (i_upd_valid)
                bht[upd_idx] <= upd_ctr;
        end
    end

    // Priority order: wb clear, data stall, alu clear, shifter/issue stalls.
    always_comb begin
        hold   = !i_clear_from_writeback &&
                 (i_data_stall ||
                  (!i_clear_from_alu && (i_stall_from_shifter || i_stall_from_issue)));
        active = !(i_clear_from_writeback || i_data_stall || i_clear_from_alu ||
                   i_stall_from_shifter || i_stall_from_issue);
    end

    always_comb begin
        is_branch    = i_dec_valid && (i_dec_instruction[27:25] == 3'b101);
        is_ret       = i_dec_valid && (i_dec_instruction[31:0] == MOV_PC_LR);
        cond_al      = (i_dec_instruction[31:28] == COND_AL);
        br_redirect  = active && is_branch && (i_dec_ctr[CTR_W-1] || cond_al);
        ret_redirect = active && is_ret && !ras_empty;
        br_target    = i_dec_pc_plus_8 +
                       ({{8{i_dec_instruction[23]}}, i_dec_instruction[23:0]}
                        << (i_dec_instruction[34] ? 1 : 2));
        push_addr    = i_dec_pc_plus_8 - (i_dec_instruction[34] ? 32'd6 : 32'd4);
        ras_push     = br_redirect && i_dec_instruction[24];
        o_clear_from_decode = br_redirect || ret_redirect;
        o_pc_from_decode    = '0;
        if (br_redirect)
            o_pc_from_decode = br_target;
        else if (ret_redirect)
            o_pc_from_decode = ras_top;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fetch_ctr <= WNT;
            o_taken_ff  <= '0;
        end else begin
            if (i_fetch_valid && !hold)
                o_fetch_ctr <= lookup_ctr;
            if (i_clear_from_writeback)
                o_taken_ff <= '0;
            else if (i_data_stall)
                o_taken_ff <= o_taken_ff;
            else if (i_clear_from_alu)
                o_taken_ff <= '0;
            else if (i_stall_from_shifter || i_stall_from_issue)
                o_taken_ff <= o_taken_ff;
            else
                o_taken_ff <= (is_branch && cond_al) ? '1 : i_dec_ctr;
        end
    end

    zap_bpred_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (ras_push),
        .i_push_data (push_addr),
        .i_pop       (ret_redirect),
        .i_flush     (i_clear_from_writeback),
        .o_top       (ras_top),
        .o_empty     (ras_empty)
    );

endmodule
